// File: rtl/door_actuator_if.sv
// Door actuator interface: upstream grants, limit switches and sensors in,
// motor drives and status out. The master side drives the inputs, the
// slave side is the actuator itself.
interface door_actuator_if;
    logic       en_left;
    logic       en_right;
    logic [3:0] din;
    logic [1:0] lim_open;
    logic [1:0] lim_closed;
    logic       obstruct;
    logic       fault_clr;
    logic [1:0] mot_open;
    logic [1:0] mot_close;
    logic       busy;
    logic       fault;
    logic [7:0] cnt_l;
    logic [7:0] cnt_r;
    logic [3:0] last_code;

    modport master (
        output en_left, en_right, din, lim_open, lim_closed, obstruct, fault_clr,
        input  mot_open, mot_close, busy, fault, cnt_l, cnt_r, last_code
    );

    modport slave (
        input  en_left, en_right, din, lim_open, lim_closed, obstruct, fault_clr,
        output mot_open, mot_close, busy, fault, cnt_l, cnt_r, last_code
    );
endinterface

// File: rtl/door_actuator.sv
// Two-door actuator sequencer: a grant rising edge starts an open / hold /
// close cycle on one side, with motion timeouts, obstruction reversal,
// a latched fault state and saturating per-side completion counters.
module door_actuator #(
    parameter int HOLD_CYC = 8,
    parameter int TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    door_actuator_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPENING,
        S_HOLD,
        S_CLOSING,
        S_FAULT
    } state_e;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CYC - 1);
    localparam logic [7:0] CNT_MAX      = 8'hFF;

    state_e     state_q, state_d;
    logic       side_q, side_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] cnt_l_q, cnt_l_d;
    logic [7:0] cnt_r_q, cnt_r_d;
    logic [3:0] last_code_q, last_code_d;
    logic       prev_l_q, prev_l_d;
    logic       prev_r_q, prev_r_d;

    logic       edge_l, edge_r;
    logic       lim_open_s, lim_closed_s;
    logic [1:0] mot_open_w, mot_close_w;
    logic       busy_w, fault_w;

    // Grants are levels; only a 0->1 transition starts a cycle.
    assign edge_l       = bus.en_left  & ~prev_l_q;
    assign edge_r       = bus.en_right & ~prev_r_q;
    assign lim_open_s   = bus.lim_open[side_q];
    assign lim_closed_s = bus.lim_closed[side_q];

    // State, timer, capture and counter registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            side_q      <= 1'b0;
            timer_q     <= '0;
            cnt_l_q     <= '0;
            cnt_r_q     <= '0;
            last_code_q <= '0;
            prev_l_q    <= 1'b0;
            prev_r_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            side_q      <= side_d;
            timer_q     <= timer_d;
            cnt_l_q     <= cnt_l_d;
            cnt_r_q     <= cnt_r_d;
            last_code_q <= last_code_d;
            prev_l_q    <= prev_l_d;
            prev_r_q    <= prev_r_d;
        end
    end

    // Next-state logic: sequencing, timeouts, obstruction reversal, counting
    always_comb begin
        state_d     = state_q;
        side_d      = side_q;
        timer_d     = timer_q;
        cnt_l_d     = cnt_l_q;
        cnt_r_d     = cnt_r_q;
        last_code_d = last_code_q;
        // Edge history tracks the grants in every state, so a grant that
        // rose while busy never fires later.
        prev_l_d    = bus.en_left;
        prev_r_d    = bus.en_right;

        case (state_q)
            S_IDLE: begin
                if (edge_l && edge_r) begin
                    // Ambiguous request: refuse to move either door.
                    state_d = S_FAULT;
                end else if (edge_l || edge_r) begin
                    state_d     = S_OPENING;
                    side_d      = edge_r;
                    last_code_d = bus.din;
                    timer_d     = '0;
                end
            end

            S_OPENING: begin
                if (lim_open_s) begin
                    state_d = S_HOLD;
                    timer_d = '0;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            S_HOLD: begin
                if (bus.obstruct) begin
                    // Keep the door open until the doorway has been clear
                    // for a full hold period.
                    timer_d = '0;
                end else if (timer_q == HOLD_LAST) begin
                    state_d = S_CLOSING;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            S_CLOSING: begin
                if (bus.obstruct) begin
                    // Safety reversal wins over the closed limit.
                    state_d = S_OPENING;
                    timer_d = '0;
                end else if (lim_closed_s) begin
                    state_d = S_IDLE;
                    if (side_q) begin
                        if (cnt_r_q != CNT_MAX) cnt_r_d = cnt_r_q + 8'd1;
                    end else begin
                        if (cnt_l_q != CNT_MAX) cnt_l_d = cnt_l_q + 8'd1;
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            S_FAULT: begin
                if (bus.fault_clr) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Moore outputs decoded from registered state and side only; reset
    // clears the state asynchronously, so the motors drop with no clock.
    always_comb begin
        mot_open_w  = 2'b00;
        mot_close_w = 2'b00;
        busy_w      = 1'b0;
        fault_w     = 1'b0;
        case (state_q)
            S_OPENING: begin
                mot_open_w[side_q] = 1'b1;
                busy_w             = 1'b1;
            end
            S_HOLD: begin
                busy_w = 1'b1;
            end
            S_CLOSING: begin
                mot_close_w[side_q] = 1'b1;
                busy_w              = 1'b1;
            end
            S_FAULT: begin
                fault_w = 1'b1;
            end
            default: begin
                busy_w = 1'b0;
            end
        endcase
    end

    assign bus.mot_open  = mot_open_w;
    assign bus.mot_close = mot_close_w;
    assign bus.busy      = busy_w;
    assign bus.fault     = fault_w;
    assign bus.cnt_l     = cnt_l_q;
    assign bus.cnt_r     = cnt_r_q;
    assign bus.last_code = last_code_q;

endmodule

// File: tb/tb_door_actuator.sv
// Scoreboarded bench for door_actuator: scripted door cycles with random
// latencies push the expected output word for every clock; a forked monitor
// compares the DUT against the queue on each falling edge.
module tb_door_actuator;

    localparam int HOLD_CYC = 8;
    localparam int TIMEOUT  = 16;

    typedef enum int { P_IDLE, P_OPEN, P_HOLD, P_CLOSE, P_FAULT } phase_e;

    typedef struct packed {
        logic [1:0] mo;
        logic [1:0] mc;
        logic       busy;
        logic       fault;
        logic [7:0] cl;
        logic [7:0] cr;
        logic [3:0] code;
    } obs_t;

    logic clk;
    logic rst;
    door_actuator_if bus();

    door_actuator #(.HOLD_CYC(HOLD_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    obs_t     exp_q[$];
    int       exp_cnt[2];
    logic [3:0] exp_code;
    int       n_tests;
    int       n_fail;
    int       cyc;

    function automatic obs_t mk(input phase_e ph, input logic s);
        obs_t o;
        o      = '0;
        o.cl   = 8'(exp_cnt[0]);
        o.cr   = 8'(exp_cnt[1]);
        o.code = exp_code;
        case (ph)
            P_OPEN:  begin o.mo[s] = 1'b1; o.busy = 1'b1; end
            P_HOLD:  o.busy = 1'b1;
            P_CLOSE: begin o.mc[s] = 1'b1; o.busy = 1'b1; end
            P_FAULT: o.fault = 1'b1;
            default: o.busy = 1'b0;
        endcase
        return o;
    endfunction

    function automatic obs_t sample();
        return {bus.mot_open, bus.mot_close, bus.busy, bus.fault,
                bus.cnt_l, bus.cnt_r, bus.last_code};
    endfunction

    task automatic compare(input string name, input obs_t a, input obs_t e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got mo=%b mc=%b busy=%b fault=%b cl=%0d cr=%0d code=%b want mo=%b mc=%b busy=%b fault=%b cl=%0d cr=%0d code=%b",
                     name, cyc, a.mo, a.mc, a.busy, a.fault, a.cl, a.cr, a.code,
                     e.mo, e.mc, e.busy, e.fault, e.cl, e.cr, e.code);
        end
    endtask

    task automatic monitor();
        obs_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare("outputs", sample(), e);
            end
        end
    endtask

    // One clock with the currently applied inputs; queue what must show after it.
    task automatic tick(input phase_e ph, input logic s);
        @(posedge clk);
        #1;
        exp_q.push_back(mk(ph, s));
    endtask

    task automatic clear_and_drop();
        tick(P_FAULT, 1'b0);
        bus.fault_clr = 1'b1;
        tick(P_IDLE, 1'b0);
        bus.fault_clr = 1'b0;
        bus.en_left   = 1'b0;
        bus.en_right  = 1'b0;
        tick(P_IDLE, 1'b0);
    endtask

    task automatic open_phase(input logic s, input int olat);
        for (int i = 0; i < olat; i++) tick(P_OPEN, s);
        bus.lim_open = 2'b01 << s;
        tick(P_HOLD, s);
        bus.lim_open = 2'b00;
    endtask

    // olat: opening cycles before the open limit (<TIMEOUT); hobs: hold index
    // of a one-cycle obstruction or -1; clat: closing cycles before the closed
    // limit (TIMEOUT means it never arrives); cobs: closing index of an
    // obstruction or -1; hedge: raise the other grant during hold.
    task automatic door_cycle(input logic s, input logic [3:0] code, input int olat,
                              input int hobs_i, input int clat, input int cobs_i,
                              input bit hedge_i);
        bit again;
        int n, hobs, cobs;
        bit hedge;
        hobs  = hobs_i;
        cobs  = cobs_i;
        hedge = hedge_i;
        bus.din = code;
        if (s) bus.en_right = 1'b1; else bus.en_left = 1'b1;
        exp_code = code;
        tick(P_OPEN, s);
        do begin
            again = 1'b0;
            open_phase(s, olat);
            n = (hobs >= 0) ? hobs + 1 + HOLD_CYC : HOLD_CYC;
            for (int i = 0; i < n; i++) begin
                bus.obstruct = (i == hobs);
                if (hedge && i == 1) begin
                    if (s) bus.en_left = 1'b1; else bus.en_right = 1'b1;
                    bus.din = ~code;
                end
                tick((i == n - 1) ? P_CLOSE : P_HOLD, s);
            end
            bus.obstruct = 1'b0;
            for (int i = 0; i < clat; i++) begin
                if (i == cobs) begin
                    bus.obstruct = 1'b1;
                    tick(P_OPEN, s);
                    bus.obstruct = 1'b0;
                    again = 1'b1;
                    cobs  = -1;
                    hobs  = -1;
                    hedge = 1'b0;
                    break;
                end
                tick((i == TIMEOUT - 1) ? P_FAULT : P_CLOSE, s);
            end
        end while (again);

        if (clat >= TIMEOUT) begin
            clear_and_drop();
        end else begin
            bus.lim_closed = 2'b01 << s;
            if (exp_cnt[s] < 255) exp_cnt[s]++;
            tick(P_IDLE, s);
            bus.lim_closed = 2'b00;
            bus.en_left    = 1'b0;
            bus.en_right   = 1'b0;
            tick(P_IDLE, s);
        end
    endtask

    task automatic open_timeout(input logic s, input logic [3:0] code);
        bus.din = code;
        if (s) bus.en_right = 1'b1; else bus.en_left = 1'b1;
        exp_code = code;
        tick(P_OPEN, s);
        for (int i = 0; i < TIMEOUT; i++) tick((i == TIMEOUT - 1) ? P_FAULT : P_OPEN, s);
        clear_and_drop();
    endtask

    task automatic both_grants(input logic [3:0] code);
        bus.din      = code;
        bus.en_left  = 1'b1;
        bus.en_right = 1'b1;
        tick(P_FAULT, 1'b0);
        clear_and_drop();
    endtask

    task automatic reset_mid_close();
        bus.din     = 4'($urandom);
        bus.en_left = 1'b1;
        exp_code    = bus.din;
        tick(P_OPEN, 1'b0);
        open_phase(1'b0, 1);
        for (int i = 0; i < HOLD_CYC; i++) tick((i == HOLD_CYC - 1) ? P_CLOSE : P_HOLD, 1'b0);
        tick(P_CLOSE, 1'b0);
        tick(P_CLOSE, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        exp_code   = 4'b0000;
        compare("async_reset", sample(), mk(P_IDLE, 1'b0));
        bus.en_left  = 1'b0;
        bus.en_right = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic random_cycle();
        int olat, hobs, clat, cobs;
        logic s;
        s    = 1'($urandom);
        olat = int'($urandom_range(0, TIMEOUT - 1));
        hobs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, HOLD_CYC - 1)) : -1;
        clat = ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(0, TIMEOUT - 1));
        cobs = (clat < TIMEOUT && clat > 0 && $urandom_range(0, 2) == 0)
               ? int'($urandom_range(0, clat - 1)) : -1;
        door_cycle(s, 4'($urandom), olat, hobs, clat, cobs, 1'($urandom));
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        cyc        = 0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        exp_code   = 4'b0000;
        rst            = 1'b1;
        bus.en_left    = 1'b1;
        bus.en_right   = 1'b0;
        bus.din        = 4'b1010;
        bus.lim_open   = 2'b00;
        bus.lim_closed = 2'b00;
        bus.obstruct   = 1'b0;
        bus.fault_clr  = 1'b0;
        fork
            monitor();
        join_none
        #12;
        compare("reset_state", sample(), mk(P_IDLE, 1'b0));
        #10;
        rst = 1'b0;

        // Grant held through reset is an edge; basic left cycle.
        door_cycle(1'b0, 4'b1010, 2, -1, 5, -1, 1'b0);
        // Right cycle with reversal during closing.
        door_cycle(1'b1, 4'b0110, 3, -1, 6, 2, 1'b0);
        // Opening never reaches the limit.
        open_timeout(1'b0, 4'b0011);
        // Simultaneous grants, then a grant edge during hold.
        both_grants(4'b1111);
        door_cycle(1'b1, 4'b0101, 1, -1, 3, -1, 1'b1);
        // Closing never reaches the limit; hold obstruction.
        door_cycle(1'b0, 4'b1001, 0, 7, TIMEOUT, -1, 1'b0);

        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 9))
                0:       open_timeout(1'($urandom), 4'($urandom));
                1:       both_grants(4'($urandom));
                default: random_cycle();
            endcase
        end

        // Drive the left counter into saturation and beyond.
        for (int k = 0; k < 256; k++)
            door_cycle(1'b0, 4'($urandom), int'($urandom_range(0, 2)), -1,
                       int'($urandom_range(0, 2)), -1, 1'b0);

        reset_mid_close();
        door_cycle(1'b1, 4'b1100, 1, -1, 1, -1, 1'b0);

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected words left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/door_actuator.md
DOOR_ACTUATOR -- requirements
Module: door_actuator

Interface
REQ-001 Parameter HOLD_CYC, 8, cycles door stays open after reaching the open limit.
REQ-002 Parameter TIMEOUT, 16, max cycles allowed for an opening or closing motion.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en_left  input  1  grant for the left door, from the upstream password FSM; level, held high after grant.
REQ-006 en_right  input  1  grant for the right door, from the upstream password FSM; level, held high after grant.
REQ-007 din  input  4  accepted code from upstream, valid while either grant is high.
REQ-008 lim_open  input  2  open-limit switches; bit0 left, bit1 right.
REQ-009 lim_closed  input  2  closed-limit switches; bit0 left, bit1 right.
REQ-010 obstruct  input  1  doorway obstruction sensor.
REQ-011 fault_clr  input  1  one-cycle fault acknowledge.
REQ-012 mot_open  output  2  open-motor drive per side; bit0 left, bit1 right.
REQ-013 mot_close  output  2  close-motor drive per side.
REQ-014 busy  output  1  high in OPENING, HOLD or CLOSING.
REQ-015 fault  output  1  high in FAULT.
REQ-016 cnt_l, cnt_r  output  8 each  completed-cycle counters per side.
REQ-017 last_code  output  4  din captured at the last accepted grant.

Function
REQ-018 Registered prev copies of en_left/en_right; a grant event is a 0->1 rising edge. Prev copies update every cycle, in all states.
REQ-019 States IDLE, OPENING, HOLD, CLOSING, FAULT; 1-bit side register (0 = left, 1 = right); timer at least 8 bits wide.
REQ-020 IDLE, left edge only: side=0, last_code<=din, timer=0, next OPENING. Right edge only: same with side=1.
REQ-021 IDLE, both edges in the same cycle: next FAULT; side and last_code unchanged.
REQ-022 Grant edges outside IDLE are ignored: no capture, no queuing.
REQ-023 OPENING: mot_open[side]=1. If lim_open[side]=1, next HOLD with timer=0. Else if timer==TIMEOUT-1, next FAULT. Else timer increments.
REQ-024 HOLD: all motors 0. If obstruct=1, timer=0 and stay. Else if timer==HOLD_CYC-1, next CLOSING with timer=0. Else timer increments.
REQ-025 CLOSING: mot_close[side]=1. Priority: obstruct=1 -> OPENING with timer=0; else lim_closed[side]=1 -> IDLE and cnt[side] increments; else timer==TIMEOUT-1 -> FAULT; else timer increments.
REQ-026 Counters saturate at 255; no wrap-around.
REQ-027 FAULT: all motors 0, fault=1. fault_clr=1 -> IDLE with timer=0. Counters and last_code retained.
REQ-028 Outputs are Moore: a function of the registered state and side only, updated the cycle after a transition.
REQ-029 mot_open and mot_close are never both high on the same side; at most one motor bit is high in total.

Reset
REQ-030 rst=1 immediately forces IDLE; mot_open=0, mot_close=0, busy=0, fault=0, cnt_l=cnt_r=0, last_code=0, timer=0, side=0, prev grant copies=0.
REQ-031 rst asserted mid-motion drops motor drives asynchronously, with no clock required.
REQ-032 A grant still held high when rst releases counts as a rising edge on the first clock.

Verification
REQ-033 Left cycle: en_left 0->1 with din=1010, lim_open[0] raised 3 cycles later, lim_closed[0] raised 5 cycles into CLOSING -> mot_open=01 for 3 cycles, 8 HOLD cycles, mot_close=01, then IDLE, cnt_l=1, last_code=1010.
REQ-034 Right cycle with obstruct pulsed during CLOSING -> mot_close[1] drops and mot_open[1] reasserts the next cycle; completion gives cnt_r=1 and cnt_l unchanged.
REQ-035 OPENING with lim_open held 0 -> FAULT after exactly 16 cycles, fault=1, motors 0; fault_clr -> IDLE, busy=0.
REQ-036 en_left and en_right rise in the same cycle -> FAULT, last_code unchanged. Separately, a new edge during HOLD -> ignored.
REQ-037 Preload 255 completed left cycles, run one more -> cnt_l stays 255. rst mid-CLOSING -> all outputs zero without a clock edge.
